iram_arbitrated_multiport: RTL and testbench

//  Shared instruction RAM serving NUM_CORES fetch requesters through NUM_RD_PORTS physical read ports.
//  - A round-robin arbiter picks up to NUM_RD_PORTS requesters per cycle.
//  - Each request completes with a one-cycle valid pulse.
//  - A single write port loads programs at run time instead of relying on fixed initial contents.
//  - Sits between the per-core fetch units and program storage in the multi-core processor.

---
 rtl/iram_arbitrated_multiport.sv | 121 ++++++++++++
 tb/tb_iram_arbitrated_multiport.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_arbitrated_multiport.sv
// Shared instruction RAM for NUM_CORES fetch units, with NUM_RD_PORTS reads per cycle.
// A round-robin arbiter chooses up to NUM_RD_PORTS requesting cores each cycle.
// Each granted read returns its word and a one-cycle valid pulse in the next cycle.
// A single program-load write port takes priority over reads in any cycle it is active.
module iram_arbitrated_multiport #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 64,
    parameter int NUM_CORES    = 16,
    parameter int NUM_RD_PORTS = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    output logic [NUM_CORES*DATA_W-1:0] instr_out,
    output logic [NUM_CORES-1:0]        instr_valid,
    output logic [NUM_CORES-1:0]        addr_err,
    input  logic                        load_en,
    input  logic [ADDR_W-1:0]           load_addr,
    input  logic [DATA_W-1:0]           load_data,
    output logic                        load_busy
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]           mem_q [DEPTH];
    logic                        mem_we;

    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES*DATA_W-1:0] instr_out_q, instr_out_d;
    logic [NUM_CORES-1:0]        instr_valid_q, instr_valid_d;
    logic [NUM_CORES-1:0]        addr_err_q, addr_err_d;
    logic                        load_busy_q, load_busy_d;
    logic [NUM_CORES-1:0]        grant;

    // Round-robin grant: scan from rr_ptr, take the first NUM_RD_PORTS requesters.
    // A read completes one cycle after grant, so a core still requesting on its
    // valid cycle is simply a fresh request; no in-flight mask is needed.
    always_comb begin
        int               n_granted;
        int               idx;
        logic [PTR_W-1:0] idx_v;
        grant     = '0;
        rr_ptr_d  = rr_ptr_q;
        n_granted = 0;
        idx       = 0;
        idx_v     = '0;
        if (!load_en) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_CORES) begin
                    idx = idx - NUM_CORES;
                end
                idx_v = PTR_W'(idx);
                if (req[idx_v] && (n_granted < NUM_RD_PORTS)) begin
                    grant[idx_v] = 1'b1;
                    n_granted    = n_granted + 1;
                    rr_ptr_d     = (idx == NUM_CORES - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    // Read datapath: granted cores capture their word (or NOP when out of range).
    always_comb begin
        instr_out_d   = instr_out_q;
        instr_valid_d = '0;
        addr_err_d    = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (grant[c]) begin
                instr_valid_d[c] = 1'b1;
                if ({1'b0, addr[c*ADDR_W +: ADDR_W]} >= DEPTH_EXT) begin
                    addr_err_d[c]                   = 1'b1;
                    instr_out_d[c*DATA_W +: DATA_W] = '0;
                end else begin
                    instr_out_d[c*DATA_W +: DATA_W] = mem_q[addr[c*ADDR_W +: IDX_W]];
                end
            end
        end
    end

    // Load control: out-of-range loads are dropped rather than aliased.
    always_comb begin
        mem_we      = load_en && ({1'b0, load_addr} < DEPTH_EXT);
        load_busy_d = load_en;
    end

    // Program storage; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Control and output registers; reset drops any read granted this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            instr_out_q   <= '0;
            instr_valid_q <= '0;
            addr_err_q    <= '0;
            load_busy_q   <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
            load_busy_q   <= load_busy_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;
    assign load_busy   = load_busy_q;

endmodule

// File: tb/tb_iram_arbitrated_multiport.sv
// Scoreboard bench for iram_arbitrated_multiport with default parameters.
module tb_iram_arbitrated_multiport;

    localparam int NC = 16;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DP = 64;

    logic             clock;
    logic             reset_n;
    logic [NC-1:0]    req;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] instr_out;
    logic [NC-1:0]    instr_valid;
    logic [NC-1:0]    addr_err;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [DW-1:0]    load_data;
    logic             load_busy;

    typedef struct {
        int          cyc;
        int          core;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [DP];
    int          cyc;
    int          checks;
    int          errors;

    iram_arbitrated_multiport dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .addr        (addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .addr_err    (addr_err),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_busy   (load_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Advance one cycle, sample after the edge; cores drop req on their valid cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        req = req & ~instr_valid;
    endtask

    task automatic set_req(input int c, input int a);
        req[c]             = 1'b1;
        addr[c*AW +: AW]   = AW'(a);
    endtask

    task automatic push_exp(input int at, input int c, input int a);
        exp_t e;
        e.cyc  = at;
        e.core = c;
        e.err  = (a >= DP);
        e.data = (a >= DP) ? 16'h0000 : model[a];
        sb.push_back(e);
    endtask

    task automatic do_load(input int a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        if (a < DP) model[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (instr_valid !== '0) begin
            errors++;
            $display("FAIL reset_valid: got %h want 0", instr_valid);
        end
        checks++;
        if (instr_out !== '0) begin
            errors++;
            $display("FAIL reset_instr_out: got %h want 0", instr_out);
        end
        checks++;
        if (addr_err !== '0) begin
            errors++;
            $display("FAIL reset_addr_err: got %h want 0", addr_err);
        end
        checks++;
        if (load_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_busy: got %b want 0", load_busy);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load_read();
        exp_t e;
        int   c0;
        do_load(0, 16'h2070);
        do_load(1, 16'h4004);
        do_load(2, 16'h0000);
        do_load(3, 16'h4008);
        for (int i = 4; i < NC; i++) do_load(i, 16'hA000 + 16'(i));
        checks++;
        if (load_busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy_after_load: got %b want 1", load_busy);
        end
        c0 = cyc;
        set_req(0, 2);
        push_exp(c0 + 1, 0, 2);
        for (int n = 0; n < 4; n++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (instr_valid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL load_read_unexpected: core %0d valid at cyc %0d, none expected", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.cyc != cyc || instr_out[c*DW +: DW] !== e.data || addr_err[c] !== e.err) begin
                            errors++;
                            $display("FAIL load_read: got core %0d cyc %0d data %h err %b, want core %0d cyc %0d data %h err %b",
                                     c, cyc, instr_out[c*DW +: DW], addr_err[c], e.core, e.cyc, e.data, e.err);
                        end
                    end
                end else if (addr_err[c]) begin
                    checks++;
                    errors++;
                    $display("FAIL load_read_err_without_valid: core %0d cyc %0d", c, cyc);
                end
            end
            if (n == 0) begin
                set_req(0, 3);
                push_exp(c0 + 2, 0, 3);
            end
            if (n == 2) begin
                checks++;
                if (instr_out[15:0] !== 16'h4008 || instr_valid[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_instr_out: got data %h valid %b, want data 4008 valid 0", instr_out[15:0], instr_valid[0]);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL load_read_missing: %0d expected reads never returned", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   c0;
        do_reset();
        c0 = cyc;
        for (int i = 0; i < NC; i++) begin
            set_req(i, i);
            push_exp(c0 + 1 + i / 4, i, i);
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (instr_valid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rr_unexpected: core %0d valid at cyc %0d, none expected", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.cyc != cyc || instr_out[c*DW +: DW] !== e.data || addr_err[c] !== e.err) begin
                            errors++;
                            $display("FAIL rr_read: got core %0d cyc %0d data %h err %b, want core %0d cyc %0d data %h err %b",
                                     c, cyc, instr_out[c*DW +: DW], addr_err[c], e.core, e.cyc, e.data, e.err);
                        end
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_missing: %0d expected reads never returned", sb.size());
            sb.delete();
        end
    endtask

    // Pointer ends at 0 after the previous test; core 13 alone moves it to 14.
    task automatic test_wrap();
        exp_t e;
        int   c0;
        c0 = cyc;
        set_req(13, 13);
        push_exp(c0 + 1, 13, 13);
        for (int n = 0; n < 8; n++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (instr_valid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL wrap_unexpected: core %0d valid at cyc %0d, none expected", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.cyc != cyc || instr_out[c*DW +: DW] !== e.data || addr_err[c] !== e.err) begin
                            errors++;
                            $display("FAIL wrap_read: got core %0d cyc %0d data %h err %b, want core %0d cyc %0d data %h err %b",
                                     c, cyc, instr_out[c*DW +: DW], addr_err[c], e.core, e.cyc, e.data, e.err);
                        end
                    end
                end
            end
            if (n == 0) begin
                set_req(3, 3);
                set_req(15, 15);
                push_exp(c0 + 2, 3, 3);
                push_exp(c0 + 2, 15, 15);
            end
            if (n == 1) begin
                // Pointer should now be 4: service order 4-7, 8-11, 12-15, 0-3.
                for (int i = 0; i < NC; i++) set_req(i, i);
                for (int g = 0; g < 4; g++) begin
                    for (int j = 0; j < 4; j++) push_exp(c0 + 3 + g, ((g + 1) % 4) * 4 + j, ((g + 1) % 4) * 4 + j);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_missing: %0d expected reads never returned", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_load_priority();
        exp_t e;
        int   c0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) set_req(i, 5);
        load_en   = 1'b1;
        load_addr = 16'd5;
        load_data = 16'hBEEF;
        model[5]  = 16'hBEEF;
        for (int n = 0; n < 6; n++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (instr_valid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL load_prio_unexpected: core %0d valid at cyc %0d, none expected", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.cyc != cyc || instr_out[c*DW +: DW] !== e.data || addr_err[c] !== e.err) begin
                            errors++;
                            $display("FAIL load_prio_read: got core %0d cyc %0d data %h err %b, want core %0d cyc %0d data %h err %b",
                                     c, cyc, instr_out[c*DW +: DW], addr_err[c], e.core, e.cyc, e.data, e.err);
                        end
                    end
                end
            end
            if (n == 0) begin
                checks++;
                if (load_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL load_busy_set: got %b want 1", load_busy);
                end
                load_en = 1'b0;
                for (int i = 0; i < 4; i++) push_exp(c0 + 2, i, 5);
            end
            if (n == 1) begin
                checks++;
                if (load_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL load_busy_clear: got %b want 0", load_busy);
                end
                set_req(0, 6);
                push_exp(c0 + 3, 0, 6);
            end
            if (n == 2) begin
                load_en   = 1'b1;
                load_addr = 16'd6;
                load_data = 16'h1234;
                model[6]  = 16'h1234;
            end
            if (n == 3) begin
                load_en = 1'b0;
                set_req(1, 6);
                push_exp(c0 + 5, 1, 6);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL load_prio_missing: %0d expected reads never returned", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_addr_err();
        exp_t e;
        int   c0;
        do_load(36, 16'h3636);
        do_load(63, 16'h6363);
        do_load(100, 16'hDEAD);
        c0 = cyc;
        set_req(7, 100);
        set_req(8, 64);
        set_req(9, 63);
        push_exp(c0 + 1, 7, 100);
        push_exp(c0 + 1, 8, 64);
        push_exp(c0 + 1, 9, 63);
        for (int n = 0; n < 4; n++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (instr_valid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL addr_err_unexpected: core %0d valid at cyc %0d, none expected", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.cyc != cyc || instr_out[c*DW +: DW] !== e.data || addr_err[c] !== e.err) begin
                            errors++;
                            $display("FAIL addr_err_read: got core %0d cyc %0d data %h err %b, want core %0d cyc %0d data %h err %b",
                                     c, cyc, instr_out[c*DW +: DW], addr_err[c], e.core, e.cyc, e.data, e.err);
                        end
                    end
                end else if (addr_err[c]) begin
                    checks++;
                    errors++;
                    $display("FAIL addr_err_without_valid: core %0d cyc %0d", c, cyc);
                end
            end
            if (n == 0) begin
                set_req(7, 36);
                set_req(8, 16'hFFFF);
                push_exp(c0 + 2, 7, 36);
                push_exp(c0 + 2, 8, 16'hFFFF);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL addr_err_missing: %0d expected reads never returned", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   c0;
        load_en   = 1'b1;
        load_addr = 16'd20;
        load_data = 16'h1111;
        model[20] = 16'h1111;
        tick();
        load_en = 1'b0;
        for (int i = 2; i < 10; i++) set_req(i, i);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== '0 || addr_err !== '0 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got valid %h err %h busy %b, want all 0", instr_valid, addr_err, load_busy);
        end
        checks++;
        if (instr_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_instr_out: got %h want 0", instr_out);
        end
        tick();
        checks++;
        if (instr_valid !== '0) begin
            errors++;
            $display("FAIL reset_mid_stale_valid: got %h want 0", instr_valid);
        end
        reset_n = 1'b1;
        c0 = cyc;
        for (int i = 2; i < 10; i++) push_exp(c0 + 1 + (i - 2) / 4, i, i);
        for (int n = 0; n < 4; n++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (instr_valid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL reset_mid_unexpected: core %0d valid at cyc %0d, none expected", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.cyc != cyc || instr_out[c*DW +: DW] !== e.data || addr_err[c] !== e.err) begin
                            errors++;
                            $display("FAIL reset_mid_read: got core %0d cyc %0d data %h err %b, want core %0d cyc %0d data %h err %b",
                                     c, cyc, instr_out[c*DW +: DW], addr_err[c], e.core, e.cyc, e.data, e.err);
                        end
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_missing: %0d expected reads never returned", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req       = '0;
        addr      = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < DP; i++) model[i] = 16'h0000;

        test_reset();
        test_load_read();
        test_round_robin();
        test_wrap();
        test_load_priority();
        test_addr_err();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
